// File: rtl/opsel_if.sv
// Handshake and datapath bundle for the operand/writeback select stage.
// The master side drives requests; the slave side is the stage.
interface opsel_if #(
  parameter int WIDTH  = 16,
  parameter int NSRC   = 4,
  parameter int SEL_W  = 2,
  parameter int ADDR_W = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      inst;
  logic [WIDTH-1:0]      pc_1;
  logic [WIDTH-1:0]      a_data;
  logic [WIDTH-1:0]      b_data;
  logic [ADDR_W-1:0]     a_addr;
  logic [ADDR_W-1:0]     b_addr;
  logic                  ma;
  logic [1:0]            mb;
  logic [NSRC*WIDTH-1:0] wb_src;
  logic [SEL_W-1:0]      wb_sel;
  logic                  wb_en;
  logic [ADDR_W-1:0]     wb_addr;
  logic [WIDTH-1:0]      wb_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_a;
  logic [WIDTH-1:0]      out_b;
  logic                  sel_err;

  modport master (
    output in_valid, inst, pc_1,
    output a_data, b_data, a_addr, b_addr,
    output ma, mb, wb_src, wb_sel,
    output wb_en, wb_addr, out_ready,
    input  in_ready, wb_data, out_valid,
    input  out_a, out_b, sel_err
  );

  modport slave (
    input  in_valid, inst, pc_1,
    input  a_data, b_data, a_addr, b_addr,
    input  ma, mb, wb_src, wb_sel,
    input  wb_en, wb_addr, out_ready,
    output in_ready, wb_data, out_valid,
    output out_a, out_b, sel_err
  );
endinterface

// File: rtl/opsel_pipe.sv
// Registered operand/writeback select stage with forwarding
// and a 2-entry skid buffer between decode and execute.
module opsel_pipe #(
  parameter int WIDTH  = 16,
  parameter int IMM_W  = 12,
  parameter int NSRC   = 4,
  parameter int SEL_W  = 2,
  parameter int ADDR_W = 3
) (
  input logic   clk,
  input logic   rst,
  opsel_if.slave bus
);

  logic [WIDTH-1:0] wb_word;
  logic             sel_bad;
  logic [WIDTH-1:0] zext;
  logic [WIDTH-1:0] sext;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  logic [WIDTH-1:0] h_a, h_b;
  logic [WIDTH-1:0] t_a, t_b;
  logic [1:0]       cnt;
  logic [1:0]       cnt_nxt;
  logic             rdy;
  logic             err;
  logic             acc;
  logic             emt;

  always_comb begin
    wb_word = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (int'(bus.wb_sel) == k)
        wb_word = bus.wb_src[k*WIDTH +: WIDTH];
    end
  end

  assign sel_bad = bus.wb_en &&
                   (int'(bus.wb_sel) >= NSRC);

  always_comb begin
    zext = '0;
    zext[IMM_W-1:0] = bus.inst[IMM_W-1:0];
    sext = {WIDTH{bus.inst[IMM_W-1]}};
    sext[IMM_W-1:0] = bus.inst[IMM_W-1:0];
  end

  // Same-cycle writeback beats the stale register read.
  always_comb begin
    reg_a = bus.a_data;
    reg_b = bus.b_data;
    if (bus.wb_en && bus.wb_addr == bus.a_addr)
      reg_a = wb_word;
    if (bus.wb_en && bus.wb_addr == bus.b_addr)
      reg_b = wb_word;
  end

  always_comb begin
    op_a = bus.ma ? zext : reg_a;
    op_b = reg_b;
    unique case (bus.mb)
      2'b00: op_b = reg_b;
      2'b01: op_b = zext;
      2'b10: op_b = sext;
      2'b11: op_b = bus.pc_1;
    endcase
  end

  assign acc = bus.in_valid && rdy;
  assign emt = (cnt != 2'd0) && bus.out_ready;

  always_comb begin
    cnt_nxt = cnt;
    unique case (1'b1)
      acc && !emt: cnt_nxt = cnt + 2'd1;
      emt && !acc: cnt_nxt = cnt - 2'd1;
      default:     cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
      rdy <= 1'b1;
      err <= 1'b0;
      h_a <= '0;
      h_b <= '0;
      t_a <= '0;
      t_b <= '0;
    end else begin
      cnt <= cnt_nxt;
      rdy <= (cnt_nxt != 2'd2);
      if (sel_bad)
        err <= 1'b1;
      if (emt) begin
        h_a <= t_a;
        h_b <= t_b;
      end
      // The new entry lands at the head when the head slot is free.
      if (acc) begin
        if (cnt == 2'd0 || (cnt == 2'd1 && emt)) begin
          h_a <= op_a;
          h_b <= op_b;
        end else begin
          t_a <= op_a;
          t_b <= op_b;
        end
      end
    end
  end

  assign bus.wb_data   = wb_word;
  assign bus.in_ready  = rdy;
  assign bus.out_valid = (cnt != 2'd0);
  assign bus.out_a     = h_a;
  assign bus.out_b     = h_b;
  assign bus.sel_err   = err;

endmodule

// File: tb/tb_opsel_pipe.sv
// Scoreboard bench for opsel_pipe: driver pushes expected
// operand pairs, a negedge monitor pops on every emit.
module tb_opsel_pipe;
  localparam int W = 16;
  localparam int NS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [2*W-1:0] sb[$];

  always #5 clk = ~clk;

  opsel_if #(.WIDTH(W), .NSRC(NS), .SEL_W(2), .ADDR_W(3)) bus ();

  opsel_pipe #(
    .WIDTH(W), .IMM_W(12), .NSRC(NS),
    .SEL_W(2), .ADDR_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic void chk(string nm, logic [W-1:0] got,
                              logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL sb_empty: got emit a=%h expected none",
                 bus.out_a);
      end else begin
        logic [2*W-1:0] e;
        e = sb.pop_front();
        chk("out_a", bus.out_a, e[2*W-1:W]);
        chk("out_b", bus.out_b, e[W-1:0]);
      end
    end
  end

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.inst = '0;
    bus.pc_1 = '0;
    bus.a_data = '0;
    bus.b_data = '0;
    bus.a_addr = '0;
    bus.b_addr = '0;
    bus.ma = 1'b0;
    bus.mb = 2'b00;
    bus.wb_en = 1'b0;
    bus.wb_addr = '0;
    bus.wb_sel = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic ma, input logic [1:0] mb,
                      input logic [W-1:0] inst,
                      input logic [W-1:0] pc1,
                      input logic [W-1:0] ad,
                      input logic [W-1:0] bd,
                      input logic [2:0] aa, input logic [2:0] ba,
                      input logic wen, input logic [2:0] wad,
                      input logic [1:0] wsel,
                      input logic [W-1:0] ea,
                      input logic [W-1:0] eb);
    logic acc;
    int   budget;
    bus.ma = ma; bus.mb = mb; bus.inst = inst; bus.pc_1 = pc1;
    bus.a_data = ad; bus.b_data = bd;
    bus.a_addr = aa; bus.b_addr = ba;
    bus.wb_en = wen; bus.wb_addr = wad; bus.wb_sel = wsel;
    bus.in_valid = 1'b1;
    budget = 20;
    acc = 1'b0;
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) sb.push_back({ea, eb});
      tick();
      budget--;
    end
    if (!acc) begin
      n_chk++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
    idle_in();
  endtask

  initial begin
    int budget;
    idle_in();
    bus.out_ready = 1'b1;
    bus.wb_src = {16'hBEEF, 16'h5678, 16'h1234};
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", W'(bus.out_valid), 16'h0);
    chk("rst_in_ready", W'(bus.in_ready), 16'h1);
    chk("rst_out_a", bus.out_a, 16'h0);
    chk("rst_sel_err", W'(bus.sel_err), 16'h0);

    send(1, 2'b10, 16'h0ABC, 0, 0, 0, 0, 0, 0, 0, 0,
         16'h0ABC, 16'hFABC);
    chk("lat_out_valid", W'(bus.out_valid), 16'h1);
    send(1, 2'b11, 16'h0ABC, 16'h0101, 0, 0, 0, 0, 0, 0, 0,
         16'h0ABC, 16'h0101);
    send(1, 2'b01, 16'h0800, 0, 0, 0, 0, 0, 0, 0, 0,
         16'h0800, 16'h0800);

    bus.wb_en = 1'b1; bus.wb_sel = 2'd2;
    #1;
    chk("wb_data_src2", bus.wb_data, 16'hBEEF);
    send(0, 2'b00, 0, 0, 16'h1111, 16'h1111, 3, 3, 1, 3, 2,
         16'hBEEF, 16'hBEEF);
    send(0, 2'b00, 0, 0, 16'h1111, 16'h2222, 3, 3, 1, 4, 2,
         16'h1111, 16'h2222);
    send(0, 2'b10, 16'h0801, 0, 16'h1111, 16'h2222, 3, 3,
         1, 3, 2, 16'hBEEF, 16'hF801);
    tick();
    tick();

    // Backpressure: three requests, only two fit.
    bus.out_ready = 1'b0;
    send(1, 2'b01, 16'h0001, 0, 0, 0, 0, 0, 0, 0, 0,
         16'h0001, 16'h0001);
    send(1, 2'b01, 16'h0002, 0, 0, 0, 0, 0, 0, 0, 0,
         16'h0002, 16'h0002);
    bus.in_valid = 1'b1; bus.ma = 1'b1; bus.mb = 2'b01;
    bus.inst = 16'h0003;
    tick();
    chk("full_in_ready", W'(bus.in_ready), 16'h0);
    chk("stall_out_a", bus.out_a, 16'h0001);
    chk("stall_valid", W'(bus.out_valid), 16'h1);
    idle_in();
    bus.out_ready = 1'b1;
    tick();
    chk("drain_in_ready", W'(bus.in_ready), 16'h1);
    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk("drain_sb_empty", W'(sb.size()), 16'h0);

    // Out-of-range writeback select.
    bus.wb_en = 1'b1; bus.wb_sel = 2'd3;
    #1;
    chk("bad_sel_wb_data", bus.wb_data, 16'h0);
    tick();
    bus.wb_en = 1'b0; bus.wb_sel = 2'd0;
    chk("sel_err_set", W'(bus.sel_err), 16'h1);
    tick();
    chk("sel_err_held", W'(bus.sel_err), 16'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sel_err_clr", W'(bus.sel_err), 16'h0);

    // Reset with two entries buffered.
    bus.out_ready = 1'b0;
    send(1, 2'b01, 16'h0055, 0, 0, 0, 0, 0, 0, 0, 0,
         16'h0055, 16'h0055);
    send(1, 2'b01, 16'h0066, 0, 0, 0, 0, 0, 0, 0, 0,
         16'h0066, 16'h0066);
    chk("pre_rst_full", W'(bus.in_ready), 16'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_valid", W'(bus.out_valid), 16'h0);
    chk("mid_rst_ready", W'(bus.in_ready), 16'h1);
    chk("mid_rst_a", bus.out_a, 16'h0);
    chk("mid_rst_b", bus.out_b, 16'h0);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/opsel_pipe.md
# opsel_pipe

Parametrised, registered operand/writeback select stage for the 16-bit datapath. Each cycle it builds the A and B ALU operands from the register file, the instruction immediate or PC+1, and selects the writeback word from N result sources. Forwarding lets a same-cycle writeback override stale register data. A 2-entry skid buffer and valid/ready handshakes let it sit between decode and execute without combinational ready paths.

## Interface
- WIDTH, 16, datapath width
- IMM_W, 12, immediate field width taken from inst[IMM_W-1:0]; 1 <= IMM_W <= WIDTH
- NSRC, 4, number of writeback sources; 2 <= NSRC <= 2**SEL_W
- SEL_W, 2, width of wb_sel
- ADDR_W, 3, register address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an operand request
- in_ready  out  1  stage can accept; registered
- inst  in  WIDTH  instruction word
- pc_1  in  WIDTH  PC+1
- a_data, b_data  in  WIDTH  register file read data
- a_addr, b_addr  in  ADDR_W  register numbers of a_data/b_data
- ma  in  1  0: A = register, 1: A = zero-extended immediate
- mb  in  2  00: register, 01: zero-ext imm, 10: sign-ext imm, 11: pc_1
- wb_src  in  NSRC*WIDTH  result sources; source k at bits [k*WIDTH +: WIDTH]
- wb_sel  in  SEL_W  writeback source select
- wb_en, wb_addr  in  1, ADDR_W  writeback strobe and target register
- wb_data  out  WIDTH  selected writeback word; combinational
- out_valid  out  1  operand pair available
- out_ready  in  1  execute consumes the pair
- out_a, out_b  out  WIDTH  registered operands
- sel_err  out  1  sticky: wb_sel >= NSRC seen while wb_en = 1

## Operation
- wb_data = source wb_sel when wb_sel < NSRC, else 0. If wb_en = 1 and wb_sel >= NSRC, sel_err sets and holds until rst.
- Forwarding: when ma = 0, wb_en = 1 and wb_addr == a_addr, the A register value is wb_data instead of a_data. B is forwarded the same way using b_addr, only when mb = 00.
- Zero-ext immediate: WIDTH-IMM_W zeros, then inst[IMM_W-1:0].
- Sign-ext immediate: WIDTH-IMM_W copies of inst[IMM_W-1], then inst[IMM_W-1:0].
- Transfers:
  - Accept when in_valid & in_ready.
  - Emit when out_valid & out_ready.
  - Operands are computed and frozen at the accept cycle; later forwarding does not alter stored entries.
- Buffer: 2 entries, FIFO order; occupancy 0/1/2.
  - out_valid = occupancy > 0; out_a/out_b always show the head entry.
  - in_ready is registered: 0 when next occupancy is 2, else 1.
  - Simultaneous accept and emit leaves occupancy unchanged.
- Reset: occupancy 0, out_valid 0, out_a/out_b 0, in_ready 1, sel_err 0. Inputs are ignored in the rst cycle, and buffered entries are discarded on mid-stream reset.

## Timing
- Latency: accepted in cycle N, visible on out_a/out_b with out_valid = 1 in cycle N+1.
- Throughput: 1 transfer/cycle when out_ready stays high.
- Backpressure: with out_ready low, 2 accepts fill the buffer and in_ready drops in the cycle after the second accept. No data is lost, and no accept occurs while in_ready = 0.
- Drain: in_ready returns to 1 the cycle after the first emit from the full state.
- Output stability: out_a/out_b/out_valid hold while out_valid & !out_ready.
- wb_data and forwarding are same-cycle combinational, from wb_* to the operand capture.

## Test plan
- Reset, then ma=1, inst=0x0ABC, mb=10, IMM_W=12 -> next cycle out_a=0x0ABC, out_b=0xFABC, out_valid=1.
- mb=11, pc_1=0x0101 -> out_b=0x0101. mb=01, inst=0x0800 -> out_b=0x0800.
- Forwarding: a_addr=3, b_addr=3, a_data=0x1111, wb_en=1, wb_addr=3, wb_sel=2, src2=0xBEEF, ma=0, mb=00 -> out_a=out_b=0xBEEF. Repeat with wb_addr=4 -> 0x1111.
- Backpressure: out_ready=0, send 3 requests back-to-back -> only 2 accepted, in_ready=0. Raise out_ready -> outputs appear in order, in_ready=1 one cycle after the first emit.
- NSRC=3, wb_en=1, wb_sel=3 -> wb_data=0, sel_err=1 next cycle and held. Assert rst for 1 cycle -> sel_err=0.
- Assert rst with 2 entries buffered -> next cycle out_valid=0, in_ready=1, out_a=out_b=0.
